alu_uart_ctrl: RTL and testbench
================================

ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 Parameter NB_DATA, default 8: operand, result and UART byte width.
REQ-002 Parameter NB_OP, default 6: ALU opcode width; equals NB_DATA-2.
REQ-003 i_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 i_rx_data  input  NB_DATA  received UART byte; valid only while i_rx_done=1.
REQ-006 i_rx_done  input  1  one-cycle pulse per received byte.
REQ-007 i_tx_done  input  1  one-cycle pulse when the transmitter finishes a byte.
REQ-008 o_tx_data  output  NB_DATA  byte to transmit; held stable from o_tx_start until i_tx_done.
REQ-009 o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
REQ-010 o_alu_a / o_alu_b  output  NB_DATA each  registered ALU operands.
REQ-011 o_alu_op  output  NB_OP  registered ALU opcode; low NB_OP bits of the opcode byte.
REQ-012 i_alu_result  input  NB_DATA  combinational ALU result.
REQ-013 i_alu_carry / i_alu_zero  input  1 each  combinational ALU flags.
REQ-014 o_busy  output  1  high in every state except S_WAIT_A.

Function
REQ-015 FSM states SHALL be: S_WAIT_A, S_WAIT_B, S_WAIT_OP, S_EXEC, S_SEND_RES, S_WAIT_RES, S_SEND_FLG, S_WAIT_FLG.
REQ-016 S_WAIT_A/S_WAIT_B SHALL latch i_rx_data into o_alu_a/o_alu_b on i_rx_done and advance to the next state.
REQ-017 S_WAIT_OP SHALL latch i_rx_data[NB_OP-1:0] into o_alu_op on i_rx_done (upper bits discarded) and go to S_EXEC.
REQ-018 S_EXEC SHALL last exactly one cycle, capture i_alu_result, i_alu_carry and i_alu_zero into internal registers, and go to S_SEND_RES.
REQ-019 S_SEND_RES SHALL assert o_tx_start for exactly one cycle with o_tx_data = captured result, then go to S_WAIT_RES.
REQ-020 Latency: opcode i_rx_done at cycle N -> capture at N+1 -> o_tx_start high at N+2.
REQ-021 S_WAIT_RES SHALL remain until i_tx_done, then go to S_SEND_FLG if ALU_UART_FLAGS_EN is defined, else to S_WAIT_A.
REQ-022 S_SEND_FLG SHALL pulse o_tx_start one cycle with o_tx_data = {zeros, carry, zero} (carry bit 1, zero bit 0); S_WAIT_FLG SHALL return to S_WAIT_A on i_tx_done.
REQ-023 i_rx_done in S_EXEC, S_SEND_*, S_WAIT_* (tx states) SHALL be ignored; the byte is dropped and does not count toward the next operand.
REQ-024 i_tx_done outside S_WAIT_RES/S_WAIT_FLG SHALL be ignored.
REQ-025 Unsupported opcodes SHALL be forwarded unchanged; the captured ALU output (0, carry 0, zero 1) is transmitted normally.
REQ-026 o_alu_a, o_alu_b and o_alu_op SHALL hold their values until overwritten by the next frame's corresponding byte.
REQ-027 o_tx_start SHALL never be high for two consecutive cycles.

Reset
REQ-028 While i_rst_n=0: state S_WAIT_A; o_alu_a, o_alu_b, o_tx_data, captured result = 0; o_alu_op = 0; captured flags = 0; o_tx_start = 0; o_busy = 0.
REQ-029 Reset asserted mid-frame or mid-transmission SHALL abort the frame; after release the next received byte is operand A.

Configuration
REQ-030 Macro ALU_UART_FLAGS_EN defined: each frame returns two bytes (result, then flags byte) per REQ-022.
REQ-031 Macro ALU_UART_FLAGS_EN undefined: S_SEND_FLG/S_WAIT_FLG SHALL not exist; each frame returns only the result byte.

Verification
REQ-032 Rx 0x05, 0x03, 0x20 -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=6'b100000; o_tx_start 2 cycles after third i_rx_done with o_tx_data=0x08.
REQ-033 Rx 0xFF, 0x01, 0x20 (flags enabled) -> tx bytes 0x00 then 0x03 (carry=1, zero=1).
REQ-034 Rx 0x03, 0x05, 0x22 (flags enabled) -> tx 0xFE then 0x02.
REQ-035 Rx 0xAA during S_WAIT_RES, then frame 0x0F, 0xF0, 0x25 after i_tx_done -> 0xAA dropped, tx 0xFF.
REQ-036 Reset pulsed after operand A and B received -> all outputs 0, o_busy=0; next frame 0x0C, 0x0A, 0x24 -> tx 0x08.
REQ-037 Opcode byte 0x3F -> o_alu_op=6'b111111, tx 0x00 (flags byte 0x01 if enabled).

Source files
------------

// File: rtl/alu_uart_ctrl_if.sv
// Bus bundle between the UART/ALU controller and its environment.
// master: the controller; slave: UART receiver/transmitter and ALU side.
interface alu_uart_ctrl_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_done;
  logic               i_tx_done;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               i_alu_carry;
  logic               i_alu_zero;
  logic               o_busy;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
    output o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result, i_alu_carry, i_alu_zero,
    input  o_tx_data, o_tx_start, o_alu_a, o_alu_b, o_alu_op, o_busy
  );
endinterface

// File: rtl/alu_uart_ctrl.sv
// UART-fed ALU frame controller: receives A, B, opcode; executes; returns the
// result byte (and, with ALU_UART_FLAGS_EN defined, a {carry, zero} flags byte).
module alu_uart_ctrl #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  alu_uart_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND_RES,
    S_WAIT_RES
`ifdef ALU_UART_FLAGS_EN
    ,
    S_SEND_FLG,
    S_WAIT_FLG
`endif
  } state_t;

  state_t             state, state_n;
  logic [NB_DATA-1:0] alu_a, alu_a_n;
  logic [NB_DATA-1:0] alu_b, alu_b_n;
  logic [NB_OP-1:0]   alu_op, alu_op_n;
  logic [NB_DATA-1:0] tx_data, tx_data_n;
  logic               tx_start, tx_start_n;
  logic               busy, busy_n;
`ifdef ALU_UART_FLAGS_EN
  logic               carry_q, carry_n;
  logic               zero_q, zero_n;
`endif

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_WAIT_A;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
`ifdef ALU_UART_FLAGS_EN
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      alu_a    <= alu_a_n;
      alu_b    <= alu_b_n;
      alu_op   <= alu_op_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      busy     <= busy_n;
`ifdef ALU_UART_FLAGS_EN
      carry_q  <= carry_n;
      zero_q   <= zero_n;
`endif
    end
  end

  // Next-state and next-output logic; tx_start is a one-cycle pulse by construction.
  always_comb begin
    state_n    = state;
    alu_a_n    = alu_a;
    alu_b_n    = alu_b;
    alu_op_n   = alu_op;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
`ifdef ALU_UART_FLAGS_EN
    carry_n    = carry_q;
    zero_n     = zero_q;
`endif
    case (state)
      S_WAIT_A: begin
        if (bus.i_rx_done) begin
          alu_a_n = bus.i_rx_data;
          state_n = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.i_rx_done) begin
          alu_b_n = bus.i_rx_data;
          state_n = S_WAIT_OP;
        end
      end
      S_WAIT_OP: begin
        if (bus.i_rx_done) begin
          alu_op_n = bus.i_rx_data[NB_OP-1:0];
          state_n  = S_EXEC;
        end
      end
      S_EXEC: begin
        // o_tx_data doubles as the captured result register.
        tx_data_n  = bus.i_alu_result;
`ifdef ALU_UART_FLAGS_EN
        carry_n    = bus.i_alu_carry;
        zero_n     = bus.i_alu_zero;
`endif
        tx_start_n = 1'b1;
        state_n    = S_SEND_RES;
      end
      S_SEND_RES: begin
        state_n = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (bus.i_tx_done) begin
`ifdef ALU_UART_FLAGS_EN
          tx_data_n  = {(NB_DATA-2)'(0), carry_q, zero_q};
          tx_start_n = 1'b1;
          state_n    = S_SEND_FLG;
`else
          state_n    = S_WAIT_A;
`endif
        end
      end
`ifdef ALU_UART_FLAGS_EN
      S_SEND_FLG: begin
        state_n = S_WAIT_FLG;
      end
      S_WAIT_FLG: begin
        if (bus.i_tx_done) begin
          state_n = S_WAIT_A;
        end
      end
`endif
      default: begin
        state_n = S_WAIT_A;
      end
    endcase
    busy_n = (state_n != S_WAIT_A);
  end

  // Drive the bus from the registered values.
  assign bus.o_alu_a    = alu_a;
  assign bus.o_alu_b    = alu_b;
  assign bus.o_alu_op   = alu_op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = busy;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: vector table, randomized frames
// against a reference model, and hand-written reset / drop sequences.
// Honours ALU_UART_FLAGS_EN (expects the extra flags byte when defined).
module tb_alu_uart_ctrl;

  logic i_clk;
  logic i_rst_n;
  int   n_checks;
  int   n_fail;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference ALU: returns {carry, zero, result} from plain integer arithmetic.
  function automatic logic [9:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    int   sa;
    int   sb;
    int   r;
    logic c;
    sa = int'(a);
    sb = int'(b);
    c  = 1'b0;
    case (op)
      6'h20: begin r = sa + sb; c = (r > 255); end
      6'h22: begin r = sa - sb; c = (sa < sb); end
      6'h24: r = sa & sb;
      6'h25: r = sa | sb;
      6'h26: r = sa ^ sb;
      6'h27: r = 255 - (sa | sb);
      default: r = 0;
    endcase
    r = r & 255;
    return {c, (r == 0), 8'(r)};
  endfunction

  // Environment ALU seen by the DUT: combinational on the registered operands.
  always_comb begin
    {bus.i_alu_carry, bus.i_alu_zero, bus.i_alu_result} =
      alu_model(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // One received byte: optional idle gap, then a one-cycle rx_done pulse.
  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) @(negedge i_clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge i_clk);
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
  endtask

  // Entered on the negedge where tx_start is high; finishes the byte with tx_done.
  task automatic handle_tx(input string name, input logic [7:0] exp, input bit inject);
    @(negedge i_clk);
    check({name, "_no_b2b"}, 32'(bus.o_tx_start), 32'd0);
    if (inject) begin
      bus.i_rx_data = 8'hAA;
      bus.i_rx_done = 1'b1;
      @(negedge i_clk);
      bus.i_rx_done = 1'b0;
      check({name, "_inj_nostart"}, 32'(bus.o_tx_start), 32'd0);
    end
    repeat ($urandom_range(0, 3)) @(negedge i_clk);
    check({name, "_hold"}, 32'(bus.o_tx_data), 32'(exp));
    check({name, "_busy_tx"}, 32'(bus.o_busy), 32'd1);
    bus.i_tx_done = 1'b1;
    @(negedge i_clk);
    bus.i_tx_done = 1'b0;
  endtask

  // Full frame with exact latency and returned-byte checks.
  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res,
                           input logic [7:0] exp_flg, input logic [5:0] exp_op,
                           input bit inject);
    send_byte(a);
    check({name, "_busy_a"}, 32'(bus.o_busy), 32'd1);
    send_byte(b);
    bus.i_rx_data = op;
    bus.i_rx_done = 1'b1;
    @(negedge i_clk);
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'($urandom);
    check({name, "_early"}, 32'(bus.o_tx_start), 32'd0);
    check({name, "_a"}, 32'(bus.o_alu_a), 32'(a));
    check({name, "_b"}, 32'(bus.o_alu_b), 32'(b));
    check({name, "_op"}, 32'(bus.o_alu_op), 32'(exp_op));
    @(negedge i_clk);
    check({name, "_start"}, 32'(bus.o_tx_start), 32'd1);
    check({name, "_res"}, 32'(bus.o_tx_data), 32'(exp_res));
    handle_tx({name, "_r"}, exp_res, inject);
`ifdef ALU_UART_FLAGS_EN
    check({name, "_fstart"}, 32'(bus.o_tx_start), 32'd1);
    check({name, "_flg"}, 32'(bus.o_tx_data), 32'(exp_flg));
    handle_tx({name, "_f"}, exp_flg, 1'b0);
`else
    check({name, "_nflg"}, 32'(bus.o_tx_start), 32'd0);
    if (exp_flg > 8'h03) $display("FAIL %s_flgvec: got 0x%0h", name, exp_flg);
`endif
    check({name, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_a"}, 32'(bus.o_alu_a), 32'd0);
    check({name, "_b"}, 32'(bus.o_alu_b), 32'd0);
    check({name, "_op"}, 32'(bus.o_alu_op), 32'd0);
    check({name, "_txd"}, 32'(bus.o_tx_data), 32'd0);
    check({name, "_txs"}, 32'(bus.o_tx_start), 32'd0);
    check({name, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    logic [7:0] flg;
    logic [5:0] aop;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] ops[8];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] rop;
    logic [9:0] m;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 6'h20};
    vecs[1] = '{8'hFF, 8'h01, 8'h20, 8'h00, 8'h03, 6'h20};
    vecs[2] = '{8'h03, 8'h05, 8'h22, 8'hFE, 8'h02, 6'h22};
    vecs[3] = '{8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 6'h25};
    vecs[4] = '{8'h0C, 8'h0A, 8'h24, 8'h08, 8'h00, 6'h24};
    vecs[5] = '{8'h12, 8'h34, 8'h3F, 8'h00, 8'h01, 6'h3F};
    vecs[6] = '{8'h0A, 8'h14, 8'hE0, 8'h1E, 8'h00, 6'h20};
    ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h3F, 8'h00};

    i_rst_n       = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("rst0");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // tx_done while idle must be ignored.
    bus.i_tx_done = 1'b1;
    @(negedge i_clk);
    bus.i_tx_done = 1'b0;
    check("spur_txd_busy", 32'(bus.o_busy), 32'd0);
    check("spur_txd_start", 32'(bus.o_tx_start), 32'd0);

    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].res, vecs[i].flg, vecs[i].aop, 1'b0);
    end

    // Byte arriving while waiting for tx_done is dropped.
    run_frame("drop_pre", 8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 6'h20, 1'b1);
    run_frame("drop", 8'h0F, 8'hF0, 8'h25, 8'hFF, 8'h00, 6'h25, 1'b0);

    // Reset after operands A and B: frame aborted, next byte is A.
    send_byte(8'h11);
    send_byte(8'h22);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_frame("after_rst", 8'h0C, 8'h0A, 8'h24, 8'h08, 8'h00, 6'h24, 1'b0);

    // Reset while waiting for the transmitter.
    send_byte(8'h40);
    send_byte(8'h02);
    send_byte(8'h26);
    repeat (4) @(negedge i_clk);
    check("rst_tx_busy_pre", 32'(bus.o_busy), 32'd1);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_tx");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_frame("after_rst_tx", 8'h33, 8'h0F, 8'h26, 8'h3C, 8'h00, 6'h26, 1'b0);

    // Randomized frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = ops[$urandom_range(0, 7)];
      if (rop == 8'h00) rop = 8'($urandom);
      rop = {2'($urandom), rop[5:0]};
      m   = alu_model(ra, rb, rop[5:0]);
      run_frame($sformatf("rnd%0d", i), ra, rb, rop, m[7:0], {6'd0, m[9], m[8]},
                rop[5:0], ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
